// File: rtl/buf_pkg.sv
// Shared types for the inbuf/outbuf stream buffers and their checkers.
`include "def.svh"

package buf_pkg;

   localparam int DATA_W = `NUM;

   // Encoded as {cvalid, svalid}; 2'b01 is never legal.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      HALF  = 2'b10,
      FULL  = 2'b11
   } buf_state_t;

endpackage

// File: rtl/def.svh
// Shared constants for the stream buffers.
`ifndef DEF_SVH
`define DEF_SVH

`define NUM 16

`endif

// File: rtl/inbuf_chk.sv
// Immediate-assertion checker bound into every inbuf instance.
`ifndef INBUF_CHK_SV
`define INBUF_CHK_SV

module inbuf_chk
   import buf_pkg::*;
(
   input logic                       clk,
   input logic                       rst,
   input logic                       cvalid,
   input logic                       svalid,
   input logic                       cstop,
   input logic signed [DATA_W-1:0]   cdata
);

   logic                     hold_q;
   logic signed [DATA_W-1:0] cdata_q;

   // A stalled beat on the core side must not move until it is consumed.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(!cvalid && svalid));
      end
      if (hold_q) begin
         assert (cdata == cdata_q);
      end
      hold_q  <= cvalid && cstop && !rst;
      cdata_q <= cdata;
   end

endmodule

bind inbuf inbuf_chk u_inbuf_chk (
   .clk    (clk),
   .rst    (rst),
   .cvalid (cvalid),
   .svalid (svalid),
   .cstop  (cstop),
   .cdata  (cdata)
);

`endif

// File: rtl/inbuf.sv
// Input-side two-entry skid buffer between the upstream link and the core.
// istop is taken straight from the skid-valid flop, so cstop never reaches it combinationally.
`ifndef INBUF_SV
`define INBUF_SV

`include "def.svh"

module inbuf
   import buf_pkg::*;
#(
   parameter int CNTW = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic signed [`NUM-1:0] idata,
   input  logic                   ivalid,
   output logic                   istop,
   output logic signed [`NUM-1:0] cdata,
   output logic                   cvalid,
   input  logic                   cstop,
   output logic [CNTW-1:0]        icount
);

   buf_state_t state;
   buf_state_t state_next;

   logic signed [`NUM-1:0] sdata;
   logic svalid;
   logic acc;
   logic con;
   logic load_in;
   logic load_skid;
   logic capture_skid;

   // The state register bits are the valid flags themselves.
   assign cvalid = state[1];
   assign svalid = state[0];
   assign istop  = svalid;

   assign acc = ivalid && !istop;
   assign con = cvalid && !cstop;

   always_comb begin
      state_next   = state;
      load_in      = 1'b0;
      load_skid    = 1'b0;
      capture_skid = 1'b0;
      case (state)
         EMPTY: begin
            if (ivalid) begin
               load_in    = 1'b1;
               state_next = HALF;
            end
         end
         HALF: begin
            if (con && ivalid) begin
               load_in = 1'b1;
            end else if (con) begin
               state_next = EMPTY;
            end else if (ivalid) begin
               capture_skid = 1'b1;
               state_next   = FULL;
            end
         end
         FULL: begin
            // Upstream is stopped here, so the skid must drain before new data reaches main.
            if (con) begin
               load_skid  = 1'b1;
               state_next = HALF;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= EMPTY;
         cdata  <= '0;
         sdata  <= '0;
         icount <= '0;
      end else begin
         state <= state_next;
         if (load_in) begin
            cdata <= idata;
         end else if (load_skid) begin
            cdata <= sdata;
         end
         if (capture_skid) begin
            sdata <= idata;
         end
         if (acc) begin
            icount <= icount + CNTW'(1);
         end
      end
   end

endmodule

`endif

// File: tb/tb_inbuf.sv
// Scoreboard bench for inbuf: accepted upstream beats are queued and popped as the core consumes them.
module tb_inbuf;
   import buf_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic signed [DATA_W-1:0] idata;
   logic ivalid;
   logic cstop;

   logic                     istop;
   logic signed [DATA_W-1:0] cdata;
   logic                     cvalid;
   logic [31:0]              icount;

   logic                     istop_w;
   logic signed [DATA_W-1:0] cdata_w;
   logic                     cvalid_w;
   logic [2:0]               icount_w;

   int checks = 0;
   int failures = 0;
   logic signed [DATA_W-1:0] exp_q[$];

   always #5 clk = ~clk;

   inbuf #(.CNTW(32)) dut (
      .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .istop(istop),
      .cdata(cdata), .cvalid(cvalid), .cstop(cstop), .icount(icount)
   );

   inbuf #(.CNTW(3)) dut_w (
      .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .istop(istop_w),
      .cdata(cdata_w), .cvalid(cvalid_w), .cstop(cstop), .icount(icount_w)
   );

   task automatic check_value(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_beat(input int value, input logic stop);
      idata  = DATA_W'(value);
      ivalid = 1'b1;
      cstop  = stop;
      tick();
   endtask

   task automatic idle(input int cycles);
      ivalid = 1'b0;
      cstop  = 1'b0;
      for (int i = 0; i < cycles; i++) tick();
   endtask

   // Scoreboard: record upstream accepts and check core-side consumes just before each edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
         end else begin
            if (cvalid && !cstop) begin
               if (exp_q.size() == 0) begin
                  check_value("unexpected_beat", cdata, 0);
                  checks++;
                  failures++;
                  $display("[TB] FAIL core_consume: got beat %0d, expected none", cdata);
               end else begin
                  check_value("core_beat", cdata, exp_q.pop_front());
               end
            end
            if (ivalid && !istop) begin
               exp_q.push_back(idata);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; ivalid = 1'b0; cstop = 1'b0; idata = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_value("reset_cvalid", cvalid, 0);
      check_value("reset_istop", istop, 0);
      check_value("reset_icount", icount, 0);

      // Full-rate stream with no backpressure.
      for (int i = 0; i < 8; i++) begin
         apply_beat(i - 4, 1'b0);
         check_value("stream_istop", istop, 0);
         if (i == 0) begin
            check_value("first_cvalid", cvalid, 1);
            check_value("first_cdata", cdata, -4);
         end
      end
      idle(2);
      check_value("stream_icount", icount, 8);
      check_value("stream_drained", exp_q.size(), 0);

      // Core stalls from the second beat onward.
      apply_beat(10, 1'b0);
      apply_beat(11, 1'b1);
      check_value("stall_cdata", cdata, 10);
      check_value("stall_istop", istop, 1);
      apply_beat(12, 1'b1);
      check_value("stall_hold_cdata", cdata, 10);
      check_value("stall_hold_istop", istop, 1);
      apply_beat(12, 1'b0);
      check_value("release_istop", istop, 0);
      check_value("release_cdata", cdata, 11);
      apply_beat(12, 1'b0);
      check_value("resume_cdata", cdata, 12);
      idle(2);
      check_value("stall_drained", exp_q.size(), 0);
      check_value("stall_icount", icount, 11);

      // Same-edge consume and reload in HALF.
      apply_beat(5, 1'b0);
      check_value("half_cdata", cdata, 5);
      apply_beat(6, 1'b0);
      check_value("reload_cdata", cdata, 6);
      check_value("reload_cvalid", cvalid, 1);
      check_value("reload_istop", istop, 0);
      idle(2);

      // Reset while FULL discards both buffered beats and the beat offered in the reset cycle.
      apply_beat(7, 1'b1);
      apply_beat(8, 1'b1);
      check_value("full_istop", istop, 1);
      rst = 1'b1;
      idata = DATA_W'(99);
      tick();
      rst = 1'b0;
      ivalid = 1'b0;
      cstop = 1'b0;
      check_value("rst_cvalid", cvalid, 0);
      check_value("rst_istop", istop, 0);
      check_value("rst_icount", icount, 0);
      check_value("rst_icount_w", icount_w, 0);
      check_value("rst_cdata", cdata, 0);
      tick();
      check_value("rst_idle_cvalid", cvalid, 0);
      apply_beat(9, 1'b0);
      check_value("post_rst_cdata", cdata, 9);
      idle(2);

      // Eight more beats bring the 3-bit counter through its wrap.
      for (int i = 0; i < 8; i++) apply_beat(20 + i, 1'b0);
      idle(2);
      check_value("wrap_icount_w", icount_w, 1);
      check_value("wide_icount", icount, 9);
      check_value("final_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
